// File: rtl/wb_port_arbiter_pkg.sv
// wb_pkg: shared definitions for the writeback port arbiter.
//   - wb_write_e : register-file write-enable encoding (port 1 always fills first)
//   - WB_DW/WB_AW: default data and register-address widths
//   - wb_cost    : slot cost of an effective write mask
//   - wb_encode  : number of occupied write ports -> write-enable encoding
package wb_pkg;

    localparam int WB_DW = 32;
    localparam int WB_AW = 5;

    typedef enum logic [1:0] {
        WB_NONE = 2'b00,
        WB_ONE  = 2'b01,
        WB_TWO  = 2'b11
    } wb_write_e;

    // Number of register-file writes a (collapsed) two-bit mask consumes.
    function automatic logic [1:0] wb_cost(input logic [1:0] mask);
        wb_cost = {1'b0, mask[0]} + {1'b0, mask[1]};
    endfunction

    // Occupied port count to bus encoding; 2'b10 can never be produced.
    function automatic wb_write_e wb_encode(input logic [1:0] nwr);
        case (nwr)
            2'd0:    wb_encode = WB_NONE;
            2'd1:    wb_encode = WB_ONE;
            2'd2:    wb_encode = WB_TWO;
            default: wb_encode = WB_NONE;
        endcase
    endfunction

endpackage

// File: rtl/wb_port_arbiter_rr_scan.sv
// wb_rr_scan: combinational round-robin scan that packs up to two register
// writes per cycle from NREQ requesters.
// Ports:
//   i_valid    requester has a pending bundle
//   i_emask    effective (already collapsed) write masks, 2 bits per requester
//   i_a1/i_a2  first/second addresses, AW bits per requester
//   i_ptr      round-robin start index
//   o_grant    bundles accepted this cycle
//   o_sel*_idx requester feeding write port 1/2
//   o_sel*_hi  0 -> port takes (d1,a1), 1 -> port takes (d2,a2)
//   o_nwr      number of write ports occupied (0..2)
//   o_adv      at least one grant with non-zero cost
//   o_last     index of the last grant with non-zero cost
module wb_rr_scan
    import wb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int AW   = WB_AW,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]    i_valid,
    input  logic [2*NREQ-1:0]  i_emask,
    input  logic [AW*NREQ-1:0] i_a1,
    input  logic [AW*NREQ-1:0] i_a2,
    input  logic [IW-1:0]      i_ptr,
    output logic [NREQ-1:0]    o_grant,
    output logic [IW-1:0]      o_sel1_idx,
    output logic               o_sel1_hi,
    output logic [IW-1:0]      o_sel2_idx,
    output logic               o_sel2_hi,
    output logic [1:0]         o_nwr,
    output logic               o_adv,
    output logic [IW-1:0]      o_last
);

    logic [IW:0]   w_sum;
    logic [IW-1:0] w_idx;
    logic [1:0]    w_m;
    logic [1:0]    w_cost;
    logic [1:0]    w_used;
    logic [AW-1:0] w_ca1;
    logic [AW-1:0] w_ca2;
    logic [AW-1:0] w_s1a;
    logic [AW-1:0] w_s2a;
    logic          w_hit;

    // Walk requesters from the pointer, granting every bundle that fits the
    // remaining slots and touches no address already granted this cycle.
    // Refused requesters are skipped, so later ones may still be granted.
    always_comb begin
        o_grant    = '0;
        o_sel1_idx = '0;
        o_sel1_hi  = 1'b0;
        o_sel2_idx = '0;
        o_sel2_hi  = 1'b0;
        o_adv      = 1'b0;
        o_last     = '0;
        w_sum      = '0;
        w_idx      = '0;
        w_m        = 2'b00;
        w_cost     = 2'd0;
        w_used     = 2'd0;
        w_ca1      = '0;
        w_ca2      = '0;
        w_s1a      = '0;
        w_s2a      = '0;
        w_hit      = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            // ptr + k stays below 2*NREQ, so one conditional subtract wraps it
            w_sum = {1'b0, i_ptr} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(NREQ)) begin
                w_sum = w_sum - (IW+1)'(NREQ);
            end else begin
                w_sum = w_sum;
            end
            w_idx  = w_sum[IW-1:0];
            w_m    = i_emask[{w_idx, 1'b0} +: 2];
            w_ca1  = i_a1[w_idx*AW +: AW];
            w_ca2  = i_a2[w_idx*AW +: AW];
            w_cost = wb_cost(w_m);
            w_hit  = (w_m[0] & (((w_used != 2'd0) & (w_ca1 == w_s1a)) |
                                ((w_used == 2'd2) & (w_ca1 == w_s2a)))) |
                     (w_m[1] & (((w_used != 2'd0) & (w_ca2 == w_s1a)) |
                                ((w_used == 2'd2) & (w_ca2 == w_s2a))));
            if (i_valid[w_idx] && (w_cost <= (2'd2 - w_used)) && !w_hit) begin
                o_grant[w_idx] = 1'b1;
                if (w_m[0]) begin
                    if (w_used == 2'd0) begin
                        o_sel1_idx = w_idx;
                        o_sel1_hi  = 1'b0;
                        w_s1a      = w_ca1;
                    end else begin
                        o_sel2_idx = w_idx;
                        o_sel2_hi  = 1'b0;
                        w_s2a      = w_ca1;
                    end
                    w_used = w_used + 2'd1;
                end else begin
                    w_used = w_used;
                end
                if (w_m[1]) begin
                    if (w_used == 2'd0) begin
                        o_sel1_idx = w_idx;
                        o_sel1_hi  = 1'b1;
                        w_s1a      = w_ca2;
                    end else begin
                        o_sel2_idx = w_idx;
                        o_sel2_hi  = 1'b1;
                        w_s2a      = w_ca2;
                    end
                    w_used = w_used + 2'd1;
                end else begin
                    w_used = w_used;
                end
                if (w_cost != 2'd0) begin
                    o_adv  = 1'b1;
                    o_last = w_idx;
                end else begin
                    o_adv  = o_adv;
                end
            end else begin
                o_grant[w_idx] = 1'b0;
            end
        end
        o_nwr = w_used;
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register file's two write ports among NREQ
// writeback requesters, granting up to two writes per cycle in round-robin
// order and driving the registered write bus one cycle after acceptance.
// Ports:
//   clk, rst          clock; synchronous reset, active low
//   req_valid/ready   per-requester handshake (ready is combinational)
//   req_we            per-requester 2-bit mask: bit0 -> (d1,a1), bit1 -> (d2,a2)
//   req_d1/a1/d2/a2   per-requester data/address slices
//   write             write enables: 00 none, 01 port 1, 11 both
//   wr1/wa1, wr2/wa2  port 1 / port 2 data and address
//   busy              a valid requester was refused in the previous cycle
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int NREQ = 3,
    parameter int DW   = WB_DW,
    parameter int AW   = WB_AW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [2*NREQ-1:0]   req_we,
    input  logic [DW*NREQ-1:0]  req_d1,
    input  logic [AW*NREQ-1:0]  req_a1,
    input  logic [DW*NREQ-1:0]  req_d2,
    input  logic [AW*NREQ-1:0]  req_a2,
    output logic [1:0]          write,
    output logic [DW-1:0]       wr1,
    output logic [DW-1:0]       wr2,
    output logic [AW-1:0]       wa1,
    output logic [AW-1:0]       wa2,
    output logic                busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IW-1:0]     r_ptr;
    logic [2*NREQ-1:0] w_emask;
    logic [NREQ-1:0]   w_grant;
    logic [IW-1:0]     w_sel1_idx;
    logic [IW-1:0]     w_sel2_idx;
    logic              w_sel1_hi;
    logic              w_sel2_hi;
    logic [1:0]        w_nwr;
    logic              w_adv;
    logic [IW-1:0]     w_last;
    logic [DW-1:0]     w_wr1;
    logic [DW-1:0]     w_wr2;
    logic [AW-1:0]     w_wa1;
    logic [AW-1:0]     w_wa2;

    // Two writes to the same register in one bundle collapse to a single
    // write of d2 (the later one wins), shown as mask 10 so only (d2,a2) issues.
    always_comb begin
        w_emask = '0;
        for (int i = 0; i < NREQ; i++) begin
            if ((req_we[2*i +: 2] == 2'b11) && (req_a1[i*AW +: AW] == req_a2[i*AW +: AW])) begin
                w_emask[2*i +: 2] = 2'b10;
            end else begin
                w_emask[2*i +: 2] = req_we[2*i +: 2];
            end
        end
    end

    wb_rr_scan #(
        .NREQ (NREQ),
        .AW   (AW),
        .IW   (IW)
    ) u_scan (
        .i_valid    (req_valid),
        .i_emask    (w_emask),
        .i_a1       (req_a1),
        .i_a2       (req_a2),
        .i_ptr      (r_ptr),
        .o_grant    (w_grant),
        .o_sel1_idx (w_sel1_idx),
        .o_sel1_hi  (w_sel1_hi),
        .o_sel2_idx (w_sel2_idx),
        .o_sel2_hi  (w_sel2_hi),
        .o_nwr      (w_nwr),
        .o_adv      (w_adv),
        .o_last     (w_last)
    );

    // Nothing is accepted while reset is held, so requesters simply retry.
    assign req_ready = rst ? w_grant : {NREQ{1'b0}};

    assign w_wr1 = w_sel1_hi ? req_d2[w_sel1_idx*DW +: DW] : req_d1[w_sel1_idx*DW +: DW];
    assign w_wa1 = w_sel1_hi ? req_a2[w_sel1_idx*AW +: AW] : req_a1[w_sel1_idx*AW +: AW];
    assign w_wr2 = w_sel2_hi ? req_d2[w_sel2_idx*DW +: DW] : req_d1[w_sel2_idx*DW +: DW];
    assign w_wa2 = w_sel2_hi ? req_a2[w_sel2_idx*AW +: AW] : req_a1[w_sel2_idx*AW +: AW];

    // Output bus, stall flag and round-robin pointer; unused ports are zeroed
    // so idle cycles present a clean bus.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr <= '0;
            write <= WB_NONE;
            wr1   <= '0;
            wr2   <= '0;
            wa1   <= '0;
            wa2   <= '0;
            busy  <= 1'b0;
        end else begin
            write <= wb_encode(w_nwr);
            wr1   <= (w_nwr != 2'd0) ? w_wr1 : '0;
            wa1   <= (w_nwr != 2'd0) ? w_wa1 : '0;
            wr2   <= (w_nwr == 2'd2) ? w_wr2 : '0;
            wa2   <= (w_nwr == 2'd2) ? w_wa2 : '0;
            busy  <= |(req_valid & ~w_grant);
            // Zero-cost grants do not move the pointer
            if (w_adv) begin
                r_ptr <= (w_last == IW'(NREQ - 1)) ? '0 : w_last + IW'(1);
            end else begin
                r_ptr <= r_ptr;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
module tb_wb_port_arbiter;

    localparam int NREQ = 3;
    localparam int DW   = 32;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [2*NREQ-1:0]   req_we = '0;
    logic [DW*NREQ-1:0]  req_d1 = '0;
    logic [AW*NREQ-1:0]  req_a1 = '0;
    logic [DW*NREQ-1:0]  req_d2 = '0;
    logic [AW*NREQ-1:0]  req_a2 = '0;
    logic [1:0]          write;
    logic [DW-1:0]       wr1;
    logic [DW-1:0]       wr2;
    logic [AW-1:0]       wa1;
    logic [AW-1:0]       wa2;
    logic                busy;

    int n_vec = 0;
    int n_err = 0;

    wb_port_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_d1    (req_d1),
        .req_a1    (req_a1),
        .req_d2    (req_d2),
        .req_a2    (req_a2),
        .write     (write),
        .wr1       (wr1),
        .wr2       (wr2),
        .wa1       (wa1),
        .wa2       (wa2),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ready(input string tag, input logic [NREQ-1:0] exp);
        #1;
        chk(tag, 64'(req_ready), 64'(exp));
    endtask

    // Checks the registered bus; port 2 only when both ports are expected busy.
    task automatic chk_bus(input string tag, input logic [1:0] w,
                           input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                           input logic [AW-1:0] a2, input logic [DW-1:0] d2,
                           input logic b);
        chk({tag, ".write"}, 64'(write), 64'(w));
        chk({tag, ".busy"}, 64'(busy), 64'(b));
        if (w != 2'b00) begin
            chk({tag, ".wa1"}, 64'(wa1), 64'(a1));
            chk({tag, ".wr1"}, 64'(wr1), 64'(d1));
        end
        if (w == 2'b11) begin
            chk({tag, ".wa2"}, 64'(wa2), 64'(a2));
            chk({tag, ".wr2"}, 64'(wr2), 64'(d2));
        end
    endtask

    task automatic set_req(input int i, input logic [1:0] m,
                           input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                           input logic [AW-1:0] a2, input logic [DW-1:0] d2);
        req_valid[i]         = 1'b1;
        req_we[2*i +: 2]     = m;
        req_a1[i*AW +: AW]   = a1;
        req_d1[i*DW +: DW]   = d1;
        req_a2[i*AW +: AW]   = a2;
        req_d2[i*DW +: DW]   = d2;
    endtask

    task automatic clr(input int i);
        req_valid[i] = 1'b0;
    endtask

    initial begin
        // Reset held for two cycles with every requester valid
        set_req(0, 2'b01, 5'd10, 32'h10, 5'd0, 32'h0);
        set_req(1, 2'b01, 5'd11, 32'h11, 5'd0, 32'h0);
        set_req(2, 2'b01, 5'd12, 32'h12, 5'd0, 32'h0);
        step();
        chk_ready("rst1.ready", 3'b000);
        chk_bus("rst1", 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
        step();
        chk_ready("rst2.ready", 3'b000);
        chk_bus("rst2", 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
        rst = 1'b1;

        // Pointer 0 after release: req0 and req1 take both ports, req2 stalls
        chk_ready("post_rst.ready", 3'b011);
        step();
        chk_bus("post_rst", 2'b11, 5'd10, 32'h10, 5'd11, 32'h11, 1'b1);
        clr(0); clr(1);
        chk_ready("drain2.ready", 3'b100);
        step();
        chk_bus("drain2", 2'b01, 5'd12, 32'h12, 5'd0, 32'h0, 1'b0);

        // Single write from req0
        clr(2);
        set_req(0, 2'b01, 5'd3, 32'hA5, 5'd0, 32'h0);
        chk_ready("single.ready", 3'b001);
        step();
        chk_bus("single", 2'b01, 5'd3, 32'hA5, 5'd0, 32'h0, 1'b0);

        // Pointer is 1: req2 alone moves it back to 0
        clr(0);
        set_req(2, 2'b01, 5'd20, 32'h77, 5'd0, 32'h0);
        chk_ready("adv_a.ready", 3'b100);
        step();
        chk_bus("adv_a", 2'b01, 5'd20, 32'h77, 5'd0, 32'h0, 1'b0);

        // Mask 00 is accepted with no write and leaves the pointer at 0
        clr(2);
        set_req(1, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
        chk_ready("mask00.ready", 3'b010);
        step();
        chk_bus("mask00", 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);

        // Two-write bundle fills both ports, req1 waits one cycle
        clr(1);
        set_req(0, 2'b11, 5'd1, 32'h101, 5'd2, 32'h102);
        set_req(1, 2'b01, 5'd4, 32'h104, 5'd0, 32'h0);
        chk_ready("full.ready", 3'b001);
        step();
        chk_bus("full", 2'b11, 5'd1, 32'h101, 5'd2, 32'h102, 1'b1);
        clr(0);
        chk_ready("full_next.ready", 3'b010);
        step();
        chk_bus("full_next", 2'b01, 5'd4, 32'h104, 5'd0, 32'h0, 1'b0);

        // Pointer is 2: req2 alone moves it back to 0
        clr(1);
        set_req(2, 2'b01, 5'd21, 32'h21, 5'd0, 32'h0);
        chk_ready("adv_b.ready", 3'b100);
        step();
        chk_bus("adv_b", 2'b01, 5'd21, 32'h21, 5'd0, 32'h0, 1'b0);

        // Address conflict: req1 skipped, req2 still granted
        set_req(0, 2'b01, 5'd7, 32'h07, 5'd0, 32'h0);
        set_req(1, 2'b01, 5'd7, 32'h17, 5'd0, 32'h0);
        set_req(2, 2'b01, 5'd9, 32'h09, 5'd0, 32'h0);
        chk_ready("conflict.ready", 3'b101);
        step();
        chk_bus("conflict", 2'b11, 5'd7, 32'h07, 5'd9, 32'h09, 1'b1);
        clr(0); clr(2);
        chk_ready("conflict_next.ready", 3'b010);
        step();
        chk_bus("conflict_next", 2'b01, 5'd7, 32'h17, 5'd0, 32'h0, 1'b0);

        // Collapse a1==a2 to one write of d2; spare slot goes to req1 (ptr 2)
        clr(1);
        set_req(0, 2'b11, 5'd5, 32'h1, 5'd5, 32'h2);
        set_req(1, 2'b01, 5'd6, 32'h66, 5'd0, 32'h0);
        chk_ready("collapse2.ready", 3'b011);
        step();
        chk_bus("collapse2", 2'b11, 5'd5, 32'h2, 5'd6, 32'h66, 1'b0);
        clr(1);
        chk_ready("collapse1.ready", 3'b001);
        step();
        chk_bus("collapse1", 2'b01, 5'd5, 32'h2, 5'd0, 32'h0, 1'b0);

        // Pointer is 1: req2 alone moves it back to 0
        clr(0);
        set_req(2, 2'b01, 5'd22, 32'h22, 5'd0, 32'h0);
        chk_ready("adv_c.ready", 3'b100);
        step();
        chk_bus("adv_c", 2'b01, 5'd22, 32'h22, 5'd0, 32'h0, 1'b0);

        // Fairness: three full bundles held, grants rotate 0,1,2,0,1,2
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 2'b11, 5'(2*i + 1), 32'h1000 + 32'(i), 5'(2*i + 2), 32'h2000 + 32'(i));
        end
        for (int c = 0; c < 6; c++) begin
            int g;
            g = c % 3;
            chk_ready($sformatf("rr%0d.ready", c), 3'(3'b001 << g));
            step();
            chk_bus($sformatf("rr%0d", c), 2'b11, 5'(2*g + 1), 32'h1000 + 32'(g),
                    5'(2*g + 2), 32'h2000 + 32'(g), 1'b1);
        end

        // Move pointer to 1, then reset mid-stream: pointer must return to 0
        chk_ready("pre_rst.ready", 3'b001);
        step();
        chk_bus("pre_rst", 2'b11, 5'd1, 32'h1000, 5'd2, 32'h2000, 1'b1);
        rst = 1'b0;
        chk_ready("mid_rst.ready", 3'b000);
        step();
        chk_bus("mid_rst", 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
        rst = 1'b1;
        chk_ready("after_rst.ready", 3'b001);
        step();
        chk_bus("after_rst", 2'b11, 5'd1, 32'h1000, 5'd2, 32'h2000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
